// File: rtl/kbd_hex_pkg.sv
// Shared constants, FSM state encoding and latched-key record for kbd_hex_display.
package kbd_hex_pkg;
  localparam logic [7:0] BRK_CODE   = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_ZERO   = 7'h40;
  localparam int         MIN_DIGITS = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_BRK, ST_EXT} kbd_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       ext;
  } key_t;
endpackage

// File: rtl/kbd_hex_display_hex7seg.sv
// Nibble to active-low seven-segment pattern, bit0 = segment a. Purely combinational.
module hex7seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/kbd_hex_display.sv
// Registered PS/2 key status display: held key code/ASCII plus wrapping press counter.
// Optional E0-prefix tracking is enabled with `define KBD_EXT_CODE_EN.
module kbd_hex_display
  import kbd_hex_pkg::*;
#(
  parameter  int NUM_DIGITS = 6,
  localparam int CNT_W      = 4*(NUM_DIGITS-4)
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    code_valid,
  input  logic [7:0]              code,
  input  logic [7:0]              ascii,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    key_down,
  output logic                    ext_key,
  output logic [CNT_W-1:0]        press_count
);
  localparam logic [7*NUM_DIGITS-1:0] HEX_RST = {{(NUM_DIGITS-4){SEG_ZERO}}, {4{SEG_BLANK}}};

  kbd_state_e       state_q, state_d;
  logic             held_q, held_d;   // BRK/EXT were entered with a key held
  logic             bext_q, bext_d;   // pending break carries the E0 prefix
  key_t             cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_brk, is_ext, prev_held, data_ext, key_down_d;

  assign is_brk = (code == BRK_CODE);
`ifdef KBD_EXT_CODE_EN
  assign is_ext = (code == EXT_CODE);
`else
  assign is_ext = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    bext_d    = bext_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    prev_held = (state_q == ST_HELD) || ((state_q == ST_EXT) && held_q);
    data_ext  = (state_q == ST_EXT);
    if (code_valid) begin
      case (state_q)
        ST_BRK: begin
          if (!is_brk) begin
            if ((code == cur_q.code) && (bext_q == cur_q.ext)) begin
              state_d   = ST_IDLE;
              held_d    = 1'b0;
              cur_d.ext = 1'b0;
            end else begin
              state_d = held_q ? ST_HELD : ST_IDLE;
            end
          end
        end
        default: begin
          if (is_brk) begin
            state_d = ST_BRK;
            held_d  = prev_held;
            bext_d  = data_ext;
          end else if (is_ext) begin
            state_d = ST_EXT;
            held_d  = prev_held;
          end else begin
            state_d = ST_HELD;
            held_d  = 1'b1;
            // typematic repeat of the held code/ext pair is not a new press
            if (!(prev_held && (code == cur_q.code) && (data_ext == cur_q.ext))) begin
              cur_d.code  = code;
              cur_d.ascii = ascii;
              cur_d.ext   = data_ext;
              cnt_d       = cnt_q + CNT_W'(1);
            end
          end
        end
      endcase
    end
    key_down_d = (state_d != ST_IDLE) && held_d;
  end

  // Segments are decoded from next-state values so hex_out lands with the state.
  logic [NUM_DIGITS-1:0][3:0] nib;
  logic [NUM_DIGITS-1:0][6:0] seg, seg_d;

  always_comb begin
    nib[0] = cur_d.code[3:0];
    nib[1] = cur_d.code[7:4];
    nib[2] = cur_d.ascii[3:0];
    nib[3] = cur_d.ascii[7:4];
    for (int k = 4; k < NUM_DIGITS; k++) nib[k] = cnt_d[4*(k-4) +: 4];
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    hex7seg u_seg (.nib(nib[g]), .seg(seg[g]));
  end

  always_comb begin
    seg_d = seg;
    if (!key_down_d) seg_d[3:0] = {4{SEG_BLANK}};
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= ST_IDLE;
      held_q   <= 1'b0;
      bext_q   <= 1'b0;
      cur_q    <= '0;
      cnt_q    <= '0;
      key_down <= 1'b0;
      hex_out  <= HEX_RST;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      bext_q   <= bext_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      key_down <= key_down_d;
      hex_out  <= seg_d;
    end
  end

`ifdef KBD_EXT_CODE_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) ext_key <= 1'b0;
    else       ext_key <= cur_d.ext;
  end
`else
  assign ext_key = 1'b0;
`endif

  assign press_count = cnt_q;
endmodule
